// File: rtl/timer0_irq_sequencer_pkg.sv
// timer0_irq_sequencer_pkg: shared constants for the Timer/Counter0 interrupt
// sequencer. Holds the ISR vector addresses, the TIFR0/TIMSK0 bit positions,
// the SREG I-bit position and the sequencer state encoding.
package timer0_irq_sequencer_pkg;

    localparam int NUM_SRC = 3;

    // TIFR0 flag positions; TIMSK0 enables share the same positions
    localparam int TOV0  = 0;
    localparam int OCF0A = 1;
    localparam int OCF0B = 2;
    localparam int TOIE0  = 0;
    localparam int OCIE0A = 1;
    localparam int OCIE0B = 2;

    // SREG global interrupt enable position
    localparam int FLAGS_I = 7;

    // ISR word addresses in the vector table
    localparam logic [9:0] TIM0_COMPA_ISR = 10'h01C;
    localparam logic [9:0] TIM0_COMPB_ISR = 10'h01E;
    localparam logic [9:0] TIM0_OVF_ISR   = 10'h020;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Map a source index to its ISR address
    function automatic logic [9:0] vector_of(input logic [1:0] idx);
        case (idx)
            2'd1:    vector_of = TIM0_COMPA_ISR;
            2'd2:    vector_of = TIM0_COMPB_ISR;
            default: vector_of = TIM0_OVF_ISR;
        endcase
    endfunction

endpackage

// File: rtl/timer0_irq_sequencer_if.sv
// timer0_irq_sequencer_if: groups the timer event, I/O register and control
// unit handshake signals of the Timer0 interrupt sequencer. The slave modport
// is the sequencer's view; the master modport is the surrounding system.
interface timer0_irq_sequencer_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int I_ADDR_WIDTH = 10
);
    logic [2:0]              flag_set;
    logic [DATA_WIDTH-1:0]   mem_timsk;
    logic                    sreg_i;
    logic                    tifr_we;
    logic [DATA_WIDTH-1:0]   tifr_wdata;
    logic                    irq_ack;
    logic                    reti;
    logic [DATA_WIDTH-1:0]   mem_tifr;
    logic                    irq;
    logic [I_ADDR_WIDTH-1:0] vector;
    logic                    sreg_i_clr;
    logic                    sreg_i_set;
    logic                    in_service;

    modport master (
        output flag_set, mem_timsk, sreg_i, tifr_we, tifr_wdata, irq_ack, reti,
        input  mem_tifr, irq, vector, sreg_i_clr, sreg_i_set, in_service
    );

    modport slave (
        input  flag_set, mem_timsk, sreg_i, tifr_we, tifr_wdata, irq_ack, reti,
        output mem_tifr, irq, vector, sreg_i_clr, sreg_i_set, in_service
    );
endinterface

// File: rtl/timer0_irq_sequencer_irq_priority_select.sv
// irq_priority_select: picks one source out of three eligible requests,
// searching upward (mod 3) from the given start pointer. With the pointer
// tied to zero this is plain fixed priority 0 > 1 > 2. Purely combinational.
module irq_priority_select (
    input  logic [2:0] eligible,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic [1:0] idx,
    output logic       valid
);

    logic [2:0] cand;
    logic [2:0] shifted;

    // Walk the three candidates in rotated order, first eligible wins
    always_comb begin
        grant   = 3'b000;
        idx     = 2'd0;
        valid   = 1'b0;
        cand    = 3'd0;
        shifted = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cand = {1'b0, ptr} + 3'(i);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            shifted = eligible >> cand[1:0];
            if (!valid && shifted[0]) begin
                valid = 1'b1;
                idx   = cand[1:0];
                grant = 3'b001 << cand[1:0];
            end
        end
    end

endmodule

// File: rtl/timer0_irq_sequencer.sv
// timer0_irq_sequencer: owns the TIFR0 flag image and feeds one Timer0
// interrupt at a time to the control unit over an irq/ack handshake, pulsing
// the SREG I-bit clear on entry and set on RETI. All outputs are registered.
// Build option: define IRQ_ROUND_ROBIN_EN for rotating priority; otherwise
// overflow > compare A > compare B.
module timer0_irq_sequencer
    import timer0_irq_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int I_ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    timer0_irq_sequencer_if.slave        bus
);

    state_t                  state, state_next;
    logic [2:0]              pend_q, pend_next;
    logic [1:0]              win_q, win_next;
    logic                    irq_q, irq_next;
    logic [I_ADDR_WIDTH-1:0] vector_q, vector_next;
    logic                    clr_q, clr_next;
    logic                    set_q, set_next;
    logic                    svc_q, svc_next;

    logic [2:0] sw_clr;
    logic [2:0] ack_clr;
    logic [2:0] pend_sw;
    logic [2:0] eligible;
    logic [2:0] live;
    logic       win_live;
    logic       ptr_adv;
    logic [1:0] ptr;
    logic [2:0] sel_grant;
    logic [1:0] sel_idx;
    logic       sel_valid;

    logic unused_bits;
    assign unused_bits = ^{bus.mem_timsk[DATA_WIDTH-1:3], bus.tifr_wdata[DATA_WIDTH-1:3], sel_grant};

    assign sw_clr   = bus.tifr_we ? bus.tifr_wdata[2:0] : 3'b000;
    assign eligible = pend_q & bus.mem_timsk[2:0] & {3{bus.sreg_i}};

    // Winner still wanted this cycle: a software clear drops it unless the
    // timer re-sets the same flag in the same cycle.
    assign pend_sw  = (pend_q & ~sw_clr) | bus.flag_set;
    assign live     = pend_sw & bus.mem_timsk[2:0] & {3{bus.sreg_i}};
    assign win_live = |(live & (3'b001 << win_q));

    // Set always beats clear, whether the clear is software or acknowledge
    assign pend_next = (pend_q & ~(sw_clr | ack_clr)) | bus.flag_set;

    irq_priority_select u_sel (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (sel_grant),
        .idx      (sel_idx),
        .valid    (sel_valid)
    );

`ifdef IRQ_ROUND_ROBIN_EN
    logic [1:0] ptr_q;

    // Rotate the search start past each acknowledged source
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else if (ptr_adv) begin
            ptr_q <= (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
        end
    end

    assign ptr = ptr_q;
`else
    logic unused_ptr_adv;
    assign unused_ptr_adv = ptr_adv;
    assign ptr = 2'd0;
`endif

    // State, flag image and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            pend_q   <= 3'b000;
            win_q    <= 2'd0;
            irq_q    <= 1'b0;
            vector_q <= '0;
            clr_q    <= 1'b0;
            set_q    <= 1'b0;
            svc_q    <= 1'b0;
        end else begin
            state    <= state_next;
            pend_q   <= pend_next;
            win_q    <= win_next;
            irq_q    <= irq_next;
            vector_q <= vector_next;
            clr_q    <= clr_next;
            set_q    <= set_next;
            svc_q    <= svc_next;
        end
    end

    // Request / service sequencing
    always_comb begin
        state_next  = state;
        win_next    = win_q;
        irq_next    = irq_q;
        vector_next = vector_q;
        clr_next    = 1'b0;
        set_next    = 1'b0;
        svc_next    = svc_q;
        ack_clr     = 3'b000;
        ptr_adv     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    win_next    = sel_idx;
                    vector_next = I_ADDR_WIDTH'(vector_of(sel_idx));
                    irq_next    = 1'b1;
                    state_next  = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (bus.irq_ack) begin
                    ack_clr    = 3'b001 << win_q;
                    clr_next   = 1'b1;
                    irq_next   = 1'b0;
                    svc_next   = 1'b1;
                    ptr_adv    = 1'b1;
                    state_next = ST_SERVICE;
                end else if (!win_live) begin
                    irq_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.reti) begin
                    set_next   = 1'b1;
                    svc_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                irq_next   = 1'b0;
                svc_next   = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_tifr   = {{(DATA_WIDTH-3){1'b0}}, pend_q};
    assign bus.irq        = irq_q;
    assign bus.vector     = vector_q;
    assign bus.sreg_i_clr = clr_q;
    assign bus.sreg_i_set = set_q;
    assign bus.in_service = svc_q;

endmodule

// File: tb/tb_timer0_irq_sequencer.sv
// tb_timer0_irq_sequencer: scoreboard bench for the Timer0 interrupt
// sequencer. Expected ISR vectors are queued when flags are raised and
// checked as each request is served.
module tb_timer0_irq_sequencer;
    import timer0_irq_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    logic [9:0] exp_q[$];

    timer0_irq_sequencer_if bus ();

    timer0_irq_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flags(input logic [2:0] f);
        bus.flag_set = f;
        step();
        bus.flag_set = 3'b000;
    endtask

    function automatic int idx_of(input logic [9:0] v);
        if (v == TIM0_COMPA_ISR) return 1;
        if (v == TIM0_COMPB_ISR) return 2;
        return 0;
    endfunction

    task automatic wait_irq();
        for (int i = 0; i < 20; i++) begin
            if (bus.irq) break;
            step();
        end
        chk("irq_wait", 32'(bus.irq), 32'd1);
    endtask

    // Serve one request: ack (optionally with flags), service, RETI
    task automatic serve(input logic [2:0] fs_ack, input logic [2:0] fs_svc);
        logic [9:0] exp;
        int         k;
        wait_irq();
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'(exp_q.size()), 32'd1);
            exp = TIM0_OVF_ISR;
        end else begin
            exp = exp_q.pop_front();
        end
        k = idx_of(exp);
        chk("vector", 32'(bus.vector), 32'(exp));
        bus.irq_ack  = 1'b1;
        bus.flag_set = fs_ack;
        step();
        bus.irq_ack  = 1'b0;
        bus.flag_set = 3'b000;
        chk("irq_after_ack", 32'(bus.irq), 32'd0);
        chk("clr_pulse", 32'(bus.sreg_i_clr), 32'd1);
        chk("in_service", 32'(bus.in_service), 32'd1);
        chk("tifr_after_ack", 32'(bus.mem_tifr[k]), 32'(fs_ack[k]));
        bus.sreg_i   = 1'b0;
        bus.flag_set = fs_svc;
        step();
        bus.flag_set = 3'b000;
        chk("clr_pulse_end", 32'(bus.sreg_i_clr), 32'd0);
        step();
        bus.reti = 1'b1;
        step();
        bus.reti = 1'b0;
        chk("set_pulse", 32'(bus.sreg_i_set), 32'd1);
        chk("in_service_end", 32'(bus.in_service), 32'd0);
        bus.sreg_i = 1'b1;
        step();
        chk("set_pulse_end", 32'(bus.sreg_i_set), 32'd0);
    endtask

    initial begin
        bus.flag_set   = 3'b111;
        bus.mem_timsk  = 8'h07;
        bus.sreg_i     = 1'b1;
        bus.tifr_we    = 1'b0;
        bus.tifr_wdata = 8'h00;
        bus.irq_ack    = 1'b0;
        bus.reti       = 1'b0;

        // Reset held two cycles with all flags pulsing
        step();
        step();
        chk("rst_irq", 32'(bus.irq), 32'd0);
        chk("rst_tifr", 32'(bus.mem_tifr), 32'd0);
        reset = 1'b0;
        bus.flag_set = 3'b000;
        bus.mem_timsk = 8'h01;
        step();
        chk("rel_tifr", 32'(bus.mem_tifr), 32'd0);
        chk("rel_vector", 32'(bus.vector), 32'd0);
        chk("rel_outs", 32'({bus.irq, bus.sreg_i_clr, bus.sreg_i_set, bus.in_service}), 32'd0);

        // Single overflow with exact latency
        pulse_flags(3'b001);
        chk("ovf_tifr_n1", 32'(bus.mem_tifr), 32'h01);
        chk("ovf_irq_n1", 32'(bus.irq), 32'd0);
        step();
        chk("ovf_irq_n2", 32'(bus.irq), 32'd1);
        exp_q.push_back(TIM0_OVF_ISR);
        serve(3'b000, 3'b000);

        // Simultaneous compare A and B
        bus.mem_timsk = 8'h07;
        exp_q.push_back(TIM0_COMPA_ISR);
        exp_q.push_back(TIM0_COMPB_ISR);
        pulse_flags(3'b110);
        serve(3'b000, 3'b000);
        serve(3'b000, 3'b000);

        // All three flags re-raised during each of three services
`ifdef IRQ_ROUND_ROBIN_EN
        exp_q.push_back(TIM0_OVF_ISR);
        exp_q.push_back(TIM0_COMPA_ISR);
        exp_q.push_back(TIM0_COMPB_ISR);
        exp_q.push_back(TIM0_OVF_ISR);
        exp_q.push_back(TIM0_COMPA_ISR);
        exp_q.push_back(TIM0_COMPB_ISR);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(TIM0_OVF_ISR);
        exp_q.push_back(TIM0_COMPA_ISR);
        exp_q.push_back(TIM0_COMPB_ISR);
`endif
        pulse_flags(3'b111);
        for (int i = 0; i < 3; i++) serve(3'b000, 3'b111);
        for (int i = 0; i < 3; i++) serve(3'b000, 3'b000);
        chk("drained_tifr", 32'(bus.mem_tifr), 32'd0);

        // Withdrawal by software clear
        pulse_flags(3'b001);
        wait_irq();
        bus.tifr_we = 1'b1;
        bus.tifr_wdata = 8'h01;
        step();
        bus.tifr_we = 1'b0;
        chk("wd_irq", 32'(bus.irq), 32'd0);
        chk("wd_clr", 32'(bus.sreg_i_clr), 32'd0);
        chk("wd_tifr", 32'(bus.mem_tifr), 32'd0);
        chk("wd_vector_kept", 32'(bus.vector), 32'(TIM0_OVF_ISR));
        step();
        chk("wd_idle", 32'({bus.irq, bus.in_service}), 32'd0);

        // Withdrawal by I-bit drop, then re-request
        pulse_flags(3'b100);
        wait_irq();
        bus.sreg_i = 1'b0;
        step();
        chk("wdi_irq", 32'(bus.irq), 32'd0);
        bus.sreg_i = 1'b1;
        step();
        chk("wdi_rereq", 32'(bus.irq), 32'd1);
        exp_q.push_back(TIM0_COMPB_ISR);
        serve(3'b000, 3'b000);

        // Compare A set collides with its own acknowledge
        pulse_flags(3'b010);
        exp_q.push_back(TIM0_COMPA_ISR);
        exp_q.push_back(TIM0_COMPA_ISR);
        serve(3'b010, 3'b000);
        serve(3'b000, 3'b000);

        // I-bit low masks everything
        bus.sreg_i = 1'b0;
        pulse_flags(3'b111);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("masked_irq", 32'(bus.irq), 32'd0);
        end
        chk("masked_tifr", 32'(bus.mem_tifr), 32'h07);
        bus.sreg_i = 1'b1;
        step();
        step();
        chk("unmask_irq", 32'(bus.irq), 32'd1);
`ifdef IRQ_ROUND_ROBIN_EN
        exp_q.push_back(TIM0_COMPB_ISR);
        exp_q.push_back(TIM0_OVF_ISR);
        exp_q.push_back(TIM0_COMPA_ISR);
`else
        exp_q.push_back(TIM0_OVF_ISR);
        exp_q.push_back(TIM0_COMPA_ISR);
        exp_q.push_back(TIM0_COMPB_ISR);
`endif
        for (int i = 0; i < 3; i++) serve(3'b000, 3'b000);

        // Reset during REQUEST
        pulse_flags(3'b001);
        wait_irq();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstreq_irq", 32'(bus.irq), 32'd0);
        chk("rstreq_vector", 32'(bus.vector), 32'd0);
        chk("rstreq_tifr", 32'(bus.mem_tifr), 32'd0);

        // Reset during SERVICE, then a stray RETI
        pulse_flags(3'b001);
        wait_irq();
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstsvc_outs", 32'({bus.in_service, bus.sreg_i_clr, bus.sreg_i_set}), 32'd0);
        bus.reti = 1'b1;
        step();
        bus.reti = 1'b0;
        chk("stray_reti", 32'(bus.sreg_i_set), 32'd0);
        chk("queue_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
